// File: rtl/fir_pkg.sv
// Shared widths, tap-select encodings and saturation helpers for the FIR arithmetic stage.
package fir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int OUT_W_DEF  = 12;
  localparam int NUM_TAPS   = 4;

  typedef enum logic [1:0] {
    SEL_T0 = 2'b00,
    SEL_T1 = 2'b01,
    SEL_T2 = 2'b10,
    SEL_T3 = 2'b11
  } tap_sel_e;

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

  localparam int SAT_MAX_DEF = sat_max(OUT_W_DEF);
  localparam int SAT_MIN_DEF = sat_min(OUT_W_DEF);

endpackage

// File: rtl/fir_tap_line.sv
// Four-deep sample delay line with x_ld rising-edge detect and a saturating fill count.
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_ld,
  output logic signed [DATA_W-1:0] tap0,
  output logic signed [DATA_W-1:0] tap1,
  output logic signed [DATA_W-1:0] tap2,
  output logic signed [DATA_W-1:0] tap3,
  output logic                     full
);

  localparam int FILL_W = $clog2(NUM_TAPS + 1);

  logic              x_ld_q;
  logic              shift_en;
  logic [FILL_W-1:0] fill;

  // A held x_ld level shifts only once.
  assign shift_en = x_ld & ~x_ld_q;
  assign full     = (fill == FILL_W'(NUM_TAPS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_ld_q <= 1'b0;
      fill   <= '0;
      tap0   <= '0;
      tap1   <= '0;
      tap2   <= '0;
      tap3   <= '0;
    end else begin
      x_ld_q <= x_ld;
      if (shift_en) begin
        tap3 <= tap2;
        tap2 <= tap1;
        tap1 <= tap0;
        tap0 <= x_in;
        if (!full) fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/fir_datapath.sv
// 4-tap signed FIR MAC stage: one multiply-accumulate per strobe, saturated registered commit.
module fir_datapath
  import fir_pkg::*;
#(
  parameter int                 DATA_W = DATA_W_DEF,
  parameter int                 COEF_W = COEF_W_DEF,
  parameter int                 ACC_W  = ACC_W_DEF,
  parameter int                 OUT_W  = OUT_W_DEF,
  parameter logic signed [COEF_W-1:0] C0 = 8'sd1,
  parameter logic signed [COEF_W-1:0] C1 = 8'sd2,
  parameter logic signed [COEF_W-1:0] C2 = 8'sd2,
  parameter logic signed [COEF_W-1:0] C3 = 8'sd1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_ld,
  input  logic                     sum_ld,
  input  logic                     sum_clr,
  input  logic                     y_ld,
  input  logic [1:0]               mult_sel,
  output logic signed [OUT_W-1:0]  y_out,
  output logic                     y_valid,
  output logic                     sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(OUT_W));

  logic signed [DATA_W-1:0] tap0, tap1, tap2, tap3;
  logic                     full;
  tap_sel_e                 sel;
  logic signed [DATA_W-1:0] tap_m;
  logic signed [COEF_W-1:0] coef_m;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  product;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y_sat;
  logic                     clamp;

  fir_tap_line #(
    .DATA_W (DATA_W)
  ) u_tap_line (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .x_ld  (x_ld),
    .tap0  (tap0),
    .tap1  (tap1),
    .tap2  (tap2),
    .tap3  (tap3),
    .full  (full)
  );

  assign sel = tap_sel_e'(mult_sel);

  // Taps are the registered values, so a same-cycle shift never reaches the product.
  always_comb begin
    tap_m  = tap0;
    coef_m = C0;
    unique case (sel)
      SEL_T0: begin tap_m = tap0; coef_m = C0; end
      SEL_T1: begin tap_m = tap1; coef_m = C1; end
      SEL_T2: begin tap_m = tap2; coef_m = C2; end
      SEL_T3: begin tap_m = tap3; coef_m = C3; end
      default: begin tap_m = tap0; coef_m = C0; end
    endcase
  end

  assign prod_full = tap_m * coef_m;
  assign product   = {{(ACC_W - PROD_W){prod_full[PROD_W-1]}}, prod_full};

  always_comb begin
    y_sat = acc[OUT_W-1:0];
    clamp = 1'b0;
    if (acc > SAT_HI) begin
      y_sat = SAT_HI[OUT_W-1:0];
      clamp = 1'b1;
    end else if (acc < SAT_LO) begin
      y_sat = SAT_LO[OUT_W-1:0];
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (sum_clr)              acc <= '0;
      else if (y_ld && sum_ld)  acc <= product;
      else if (y_ld)            acc <= '0;
      else if (sum_ld)          acc <= acc + product;

      // Commit uses the pre-update acc and still happens alongside sum_clr.
      if (y_ld) y_out <= y_sat;
      y_valid <= y_ld & full;

      if (sum_clr)             sat_flag <= 1'b0;
      else if (y_ld && clamp)  sat_flag <= 1'b1;
    end
  end

endmodule
